// File: rtl/dsp_operand_pipe_if.sv
// Operand pipeline signal bundle.
// Groups the per-slice operand inputs (direct/cascade operand, source select,
// valid, per-stage enables, clear, multiplier tap select) and the three operand
// outputs with their valids.
//   master : drives operands/controls, receives ACOUT/XMUX/AMULT/XVALID/MVALID
//   slave  : the operand pipeline itself
interface dsp_operand_pipe_if #(
    parameter int unsigned WIDTH = 30
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] ACIN;
    logic             IN_SEL;
    logic             VALID_IN;
    logic [3:0]       CE;
    logic             CLR;
    logic [2:0]       MSEL;
    logic [WIDTH-1:0] ACOUT;
    logic [WIDTH-1:0] XMUX;
    logic [WIDTH-1:0] AMULT;
    logic             XVALID;
    logic             MVALID;

    modport master (
        output A, ACIN, IN_SEL, VALID_IN, CE, CLR, MSEL,
        input  ACOUT, XMUX, AMULT, XVALID, MVALID
    );

    modport slave (
        input  A, ACIN, IN_SEL, VALID_IN, CE, CLR, MSEL,
        output ACOUT, XMUX, AMULT, XVALID, MVALID
    );
endinterface

// File: rtl/dsp_operand_pipe.sv
// Generalised operand input-register pipeline for a DSP slice port (A, B or D).
// Stage 0 is the combinational source select (direct A or cascade ACIN);
// stages 1..DEPTH are registers, each with its own clock enable and valid bit.
// Ports:
//   clk   rising-edge clock
//   RSTN  asynchronous active-low reset of all stages and valid bits
//   ifc   dsp_operand_pipe_if.slave:
//           A/ACIN operands, IN_SEL source select, VALID_IN qualifier,
//           CE per-stage enables (CE[k-1] gates stage k), CLR sync clear,
//           MSEL multiplier tap select (clamped to DEPTH);
//           ACOUT = tap(CASC_TAP), XMUX/XVALID = tap(DEPTH),
//           AMULT/MVALID = tap(min(MSEL,DEPTH))
module dsp_operand_pipe #(
    parameter int unsigned WIDTH    = 30,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned CASC_TAP = 2,
    parameter bit          CASC_EN  = 1'b1
) (
    input  logic               clk,
    input  logic               RSTN,
    dsp_operand_pipe_if.slave  ifc
);

    if (CASC_TAP > DEPTH) begin : g_bad_casc_tap
        $error("dsp_operand_pipe: CASC_TAP (%0d) exceeds DEPTH (%0d)", CASC_TAP, DEPTH);
    end

    // taps[0] is the combinational input; taps[k] is register stage k.
    logic [DEPTH:0][WIDTH-1:0] taps;
    logic [DEPTH:0]            vtaps;

    assign taps[0]  = (ifc.IN_SEL && CASC_EN) ? ifc.ACIN : ifc.A;
    assign vtaps[0] = ifc.VALID_IN;

    for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] r;
        logic             v;

        always_ff @(posedge clk or negedge RSTN) begin
            if (!RSTN) begin
                r <= '0;
                v <= 1'b0;
            end else if (ifc.CLR) begin
                r <= '0;
                v <= 1'b0;
            end else if (ifc.CE[k-1]) begin
                r <= taps[k-1];
                v <= vtaps[k-1];
            end
        end

        assign taps[k]  = r;
        assign vtaps[k] = v;
    end

    // Multiplier tap: a priority chain where stage k wins once MSEL >= k.
    // The last link is taken for any MSEL >= DEPTH, which gives the clamp.
    int unsigned               msel_w;
    logic [DEPTH:0][WIDTH-1:0] mchain;
    logic [DEPTH:0]            mvchain;

    assign msel_w     = {29'd0, ifc.MSEL};
    assign mchain[0]  = taps[0];
    assign mvchain[0] = vtaps[0];

    for (genvar k = 1; k <= DEPTH; k++) begin : g_mtap
        assign mchain[k]  = (msel_w >= k) ? taps[k]  : mchain[k-1];
        assign mvchain[k] = (msel_w >= k) ? vtaps[k] : mvchain[k-1];
    end

    assign ifc.ACOUT  = taps[CASC_TAP];
    assign ifc.XMUX   = taps[DEPTH];
    assign ifc.XVALID = vtaps[DEPTH];
    assign ifc.AMULT  = mchain[DEPTH];
    assign ifc.MVALID = mvchain[DEPTH];

    // CE bits above DEPTH, and clk/RSTN/CLR when DEPTH=0, have no function.
    logic unused_inputs;
    assign unused_inputs = ^{clk, RSTN, ifc.CLR, ifc.CE};

endmodule
